// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - pipelined fetch stage with DEPTH-entry prefetch queue
//
// Ports:
//   clk, reset         clock; synchronous active-low reset
//   PCSrc_F/PCBranch_F branch redirect pulse and target
//   EProc_F/EVAddr_F   exception redirect pulse and vector (wins over branch)
//   imem_req_*         request handshake to instruction memory, address = fetch_pc
//   imem_rsp_*         response from memory (one outstanding request at most)
//   inst_*_D, pc_D     queue head handshake towards decode
//   NextPC_D           pc_D + INC
module fetch_queue #(
  parameter int            N        = 64,
  parameter int            IW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [N-1:0]  RESET_PC = '0,
  parameter int            INC      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          PCSrc_F,
  input  logic [N-1:0]  PCBranch_F,
  input  logic          EProc_F,
  input  logic [N-1:0]  EVAddr_F,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [N-1:0]  imem_addr_F,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  output logic          inst_valid_D,
  input  logic          inst_ready_D,
  output logic [IW-1:0] inst_D,
  output logic [N-1:0]  pc_D,
  output logic [N-1:0]  NextPC_D
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  fetch_pc;
  logic [N-1:0]  req_pc;
  logic          pending;
  logic          drop;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [N-1:0]  pc_mem   [DEPTH];
  logic [IW-1:0] inst_mem [DEPTH];

  logic          redirect;
  logic [N-1:0]  target;
  logic          req_fire;
  logic          rsp_take;
  logic          push;
  logic          pop;

  assign redirect = EProc_F | PCSrc_F;
  assign target   = EProc_F ? EVAddr_F : PCBranch_F;

  // Only one request in flight and only when a slot is free, so a returning
  // response always has room in the queue.
  assign imem_req_valid = reset && !pending && (count < CW'(DEPTH)) && !redirect;
  assign imem_addr_F    = fetch_pc;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_take = reset && pending && imem_rsp_valid;
  // Responses belonging to a flushed request, or arriving in a flush cycle, are dropped.
  assign push     = rsp_take && !drop && !redirect;

  assign inst_valid_D = reset && (count != '0);
  assign pop          = inst_valid_D & inst_ready_D;

  assign inst_D   = inst_mem[rd_ptr];
  assign pc_D     = pc_mem[rd_ptr];
  assign NextPC_D = pc_D + N'(INC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      pending  <= 1'b0;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (rsp_take) begin
        pending <= 1'b0;
      end
      if (redirect) begin
        fetch_pc <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // A request still outstanding after this edge must have its data thrown away.
        drop     <= pending && !imem_rsp_valid;
      end else begin
        if (req_fire) begin
          pending  <= 1'b1;
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + N'(INC);
        end
        if (rsp_take && drop) begin
          drop <= 1'b0;
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: count gates everything read out of it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue
module tb_fetch_queue;

  localparam int          N        = 64;
  localparam int          IW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          CYCLES   = 4000;

  logic          clk = 1'b0;
  logic          reset;
  logic          PCSrc_F;
  logic [N-1:0]  PCBranch_F;
  logic          EProc_F;
  logic [N-1:0]  EVAddr_F;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [N-1:0]  imem_addr_F;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          inst_valid_D;
  logic          inst_ready_D;
  logic [IW-1:0] inst_D;
  logic [N-1:0]  pc_D;
  logic [N-1:0]  NextPC_D;

  fetch_queue #(.N(N), .IW(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .INC(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .PCSrc_F        (PCSrc_F),
    .PCBranch_F     (PCBranch_F),
    .EProc_F        (EProc_F),
    .EVAddr_F       (EVAddr_F),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr_F    (imem_addr_F),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid_D   (inst_valid_D),
    .inst_ready_D   (inst_ready_D),
    .inst_D         (inst_D),
    .pc_D           (pc_D),
    .NextPC_D       (NextPC_D)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  pc;
    logic [IW-1:0] inst;
  } ent_t;

  // Scoreboard: instructions decode should see, in order.
  ent_t exp_q[$];

  // Reference model of the fetch side and of the memory.
  logic [N-1:0] model_pc;
  bit           busy;
  bit           dropped;
  int           lat;
  logic [N-1:0] mem_pc;
  bit           known;

  // Per-cycle expectations handed from the driver to the monitor.
  bit           chk_en;
  bit           exp_req_valid;
  logic [N-1:0] exp_addr;

  int checks = 0;
  int errors = 0;

  function automatic logic [N-1:0] pick_target();
    logic [N-1:0] t;
    case ($urandom_range(0, 4))
      0:       t = 64'h100;
      1:       t = 64'h200;
      2:       t = 64'h400;
      3:       t = 64'hFFFF_FFFF_FFFF_FFF8;
      default: t = {$urandom(), $urandom()} & ~64'h3;
    endcase
    return t;
  endfunction

  // Driver + model: inputs at negedge, expectations at +1, model edge update at +3.
  initial begin
    bit           redir;
    bit           fire;
    bit           hold;
    logic [N-1:0] tgt;
    reset = 1'b0; PCSrc_F = 1'b0; EProc_F = 1'b0;
    PCBranch_F = '0; EVAddr_F = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready_D = 1'b0;
    model_pc = RESET_PC; busy = 0; dropped = 0; lat = 0; mem_pc = '0; known = 0;
    chk_en = 0; exp_req_valid = 0; exp_addr = '0;
    hold = 0;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      if (cyc % 32 == 0) hold = ($urandom_range(0, 3) == 0);
      reset = (cyc >= 2) && ($urandom_range(0, 299) != 0);
      begin
        int r;
        r = $urandom_range(0, 19);
        PCSrc_F = (r == 0) || (r == 1);
        EProc_F = (r == 1) || (r == 2);
      end
      PCBranch_F     = pick_target();
      EVAddr_F       = pick_target();
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready_D   = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      imem_rsp_data  = $urandom();
      if (busy)
        imem_rsp_valid = (lat == 0);
      else
        imem_rsp_valid = ($urandom_range(0, 7) == 0);
      #1;
      redir = PCSrc_F || EProc_F;
      tgt   = EProc_F ? EVAddr_F : PCBranch_F;
      chk_en        = known;
      exp_req_valid = reset && !busy && (exp_q.size() < DEPTH) && !redir;
      exp_addr      = model_pc;
      fire          = exp_req_valid && imem_req_ready;
      #2;
      if (!reset) begin
        exp_q.delete();
        model_pc = RESET_PC; busy = 0; dropped = 0; known = 1;
      end else if (known) begin
        if (busy && imem_rsp_valid) begin
          busy = 0;
          if (!dropped && !redir) exp_q.push_back('{pc: mem_pc, inst: imem_rsp_data});
          dropped = 0;
        end else if (busy && lat > 0) begin
          lat--;
        end
        if (redir) begin
          exp_q.delete();
          model_pc = tgt;
          if (busy) dropped = 1;
        end else if (fire) begin
          busy = 1; mem_pc = model_pc; model_pc = model_pc + 64'd4;
          lat = $urandom_range(0, 3); dropped = 0;
        end
      end
    end
    @(negedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: compares DUT outputs against the expectations and pops on dequeue.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      checks++;
      if (imem_addr_F !== exp_addr) begin
        errors++;
        $display("FAIL imem_addr_F: got %h expected %h at %0t", imem_addr_F, exp_addr, $time);
      end
      checks++;
      if (imem_req_valid !== exp_req_valid) begin
        errors++;
        $display("FAIL imem_req_valid: got %b expected %b at %0t", imem_req_valid, exp_req_valid, $time);
      end
      checks++;
      if (inst_valid_D !== (reset && exp_q.size() != 0)) begin
        errors++;
        $display("FAIL inst_valid_D: got %b expected %b at %0t", inst_valid_D, (reset && exp_q.size() != 0), $time);
      end
      if (inst_valid_D === 1'b1 && exp_q.size() != 0) begin
        checks++;
        if (pc_D !== exp_q[0].pc || inst_D !== exp_q[0].inst) begin
          errors++;
          $display("FAIL head: got pc %h inst %h expected pc %h inst %h at %0t",
                   pc_D, inst_D, exp_q[0].pc, exp_q[0].inst, $time);
        end
        checks++;
        if (NextPC_D !== exp_q[0].pc + 64'd4) begin
          errors++;
          $display("FAIL NextPC_D: got %h expected %h at %0t", NextPC_D, exp_q[0].pc + 64'd4, $time);
        end
        if (inst_ready_D) void'(exp_q.pop_front());
      end
    end
  end

endmodule
